// File: rtl/ad1868_pkg.sv
// Shared widths and watchdog defaults for the AD1868-style serial receiver.
package ad1868_pkg;

    localparam int SAMPLE_W    = 16;
    localparam int SHIFT_W     = 18;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT_DEF = 24576;

    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

    localparam int CNT_W_DEF = cnt_width(TIMEOUT_DEF);

endpackage

// File: rtl/ad1868_receiver_sync_edge.sv
// Multi-stage synchroniser with a registered rising-edge detector.
module sync_edge
    import ad1868_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_level,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_d};
            last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign o_level = sync_q[SYNC_STAGES-1];
    assign o_rise  = o_level & ~last_q;

endmodule

// File: rtl/ad1868_receiver.sv
// Deserialises the BCK/DL/DR/LL/LR stream into parallel 16-bit words on MCLK,
// deferring handoff while the encoder holds and muting on source silence.
module ad1868_receiver
    import ad1868_pkg::*;
#(
    parameter int DATA_BITS = 16,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_bck,
    input  logic                i_dl,
    input  logic                i_dr,
    input  logic                i_ll,
    input  logic                i_lr,
    input  logic                i_hold,
    output logic [SAMPLE_W-1:0] o_data_l,
    output logic [SAMPLE_W-1:0] o_data_r,
    output logic                o_update,
    output logic                o_active,
    output logic                o_overrun
);

    localparam int CNT_W = cnt_width(TIMEOUT);

    logic bck_rise, ll_rise, lr_rise;
    logic bck_lvl, ll_lvl, lr_lvl;

    sync_edge u_bck (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_d    (i_bck),
        .o_level(bck_lvl),
        .o_rise (bck_rise)
    );

    sync_edge u_ll (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_d    (i_ll),
        .o_level(ll_lvl),
        .o_rise (ll_rise)
    );

    sync_edge u_lr (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_d    (i_lr),
        .o_level(lr_lvl),
        .o_rise (lr_rise)
    );

    logic [SYNC_STAGES-1:0] dl_q, dr_q, hold_q;
    logic                   dl_s, dr_s, hold_s;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            dl_q   <= '0;
            dr_q   <= '0;
            hold_q <= '0;
        end else begin
            dl_q   <= {dl_q[SYNC_STAGES-2:0], i_dl};
            dr_q   <= {dr_q[SYNC_STAGES-2:0], i_dr};
            hold_q <= {hold_q[SYNC_STAGES-2:0], i_hold};
        end
    end

    assign dl_s   = dl_q[SYNC_STAGES-1];
    assign dr_s   = dr_q[SYNC_STAGES-1];
    assign hold_s = hold_q[SYNC_STAGES-1];

    // The first 16 bits of a DATA_BITS word sit at the top of its window.
    function automatic logic [SAMPLE_W-1:0] align(input logic [SHIFT_W-1:0] s);
        logic [SHIFT_W-1:0] t;
        t = s >> (DATA_BITS - SAMPLE_W);
        return t[SAMPLE_W-1:0];
    endfunction

    logic [SHIFT_W-1:0]  shift_l, shift_r;
    logic [SAMPLE_W-1:0] pend_l, pend_r;
    logic                pend_l_flag, pend_r_flag;
    logic [CNT_W-1:0]    wd_cnt;
    logic                latch_any, mute, commit;

    assign latch_any = ll_rise | lr_rise;
    assign mute      = ~latch_any & (wd_cnt == CNT_W'(TIMEOUT - 1));
    assign commit    = ~hold_s & (pend_l_flag | pend_r_flag);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            shift_l     <= '0;
            shift_r     <= '0;
            pend_l      <= '0;
            pend_r      <= '0;
            pend_l_flag <= 1'b0;
            pend_r_flag <= 1'b0;
            wd_cnt      <= '0;
            o_data_l    <= '0;
            o_data_r    <= '0;
            o_update    <= 1'b0;
            o_active    <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            o_update <= 1'b0;

            if (bck_rise) begin
                shift_l <= {shift_l[SHIFT_W-2:0], dl_s};
                shift_r <= {shift_r[SHIFT_W-2:0], dr_s};
            end

            if (latch_any) begin
                wd_cnt <= '0;
            end else if (wd_cnt != CNT_W'(TIMEOUT)) begin
                wd_cnt <= wd_cnt + 1'b1;
            end

            if (mute) begin
                o_data_l    <= '0;
                o_data_r    <= '0;
                pend_l      <= '0;
                pend_r      <= '0;
                pend_l_flag <= 1'b0;
                pend_r_flag <= 1'b0;
                o_active    <= 1'b0;
                o_update    <= |{o_data_l, o_data_r};
            end else begin
                if (commit) begin
                    o_data_l    <= pend_l;
                    o_data_r    <= pend_r;
                    o_update    <= 1'b1;
                    o_active    <= 1'b1;
                    pend_l_flag <= 1'b0;
                    pend_r_flag <= 1'b0;
                end
                // A latch landing on a commit cycle is kept: set beats clear.
                if (ll_rise) begin
                    pend_l      <= align(shift_l);
                    pend_l_flag <= 1'b1;
                    if (pend_l_flag & ~commit) o_overrun <= 1'b1;
                end
                if (lr_rise) begin
                    pend_r      <= align(shift_r);
                    pend_r_flag <= 1'b1;
                    if (pend_r_flag & ~commit) o_overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ad1868_receiver.sv
// Directed bench for ad1868_receiver: 16-bit and 18-bit instances share stimulus.
module tb_ad1868_receiver;

    localparam int TMO = 24576;

    logic        clk = 1'b0;
    logic        i_rst, i_bck, i_dl, i_dr, i_ll, i_lr, i_hold;
    logic [15:0] l16, r16, l18, r18;
    logic        upd16, act16, ovr16, upd18, act18, ovr18;

    int checks = 0;
    int errors = 0;
    int upd_cnt = 0;

    always #20 clk = ~clk;

    ad1868_receiver u_dut16 (
        .i_clk    (clk),
        .i_rst    (i_rst),
        .i_bck    (i_bck),
        .i_dl     (i_dl),
        .i_dr     (i_dr),
        .i_ll     (i_ll),
        .i_lr     (i_lr),
        .i_hold   (i_hold),
        .o_data_l (l16),
        .o_data_r (r16),
        .o_update (upd16),
        .o_active (act16),
        .o_overrun(ovr16)
    );

    ad1868_receiver #(.DATA_BITS(18)) u_dut18 (
        .i_clk    (clk),
        .i_rst    (i_rst),
        .i_bck    (i_bck),
        .i_dl     (i_dl),
        .i_dr     (i_dr),
        .i_ll     (i_ll),
        .i_lr     (i_lr),
        .i_hold   (i_hold),
        .o_data_l (l18),
        .o_data_r (r18),
        .o_update (upd18),
        .o_active (act18),
        .o_overrun(ovr18)
    );

    always @(negedge clk) if (upd16) upd_cnt <= upd_cnt + 1;

    typedef struct {
        logic [17:0] wl;
        logic [17:0] wr;
        logic [15:0] el16;
        logic [15:0] er16;
        logic [15:0] el18;
        logic [15:0] er18;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic l, input logic r);
        i_dl  = l;
        i_dr  = r;
        i_bck = 1'b0;
        ticks(4);
        i_bck = 1'b1;
        ticks(4);
    endtask

    task automatic shift_word(input logic [17:0] l, input logic [17:0] r,
                              input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(l[i], r[i]);
    endtask

    task automatic pulse(input logic l, input logic r);
        i_ll = l;
        i_lr = r;
        ticks(4);
        i_ll = 1'b0;
        i_lr = 1'b0;
        ticks(4);
    endtask

    initial begin
        int base;
        int n;
        logic changed;

        vecs[0] = '{18'h2AAAB, 18'h15554, 16'hAAAB, 16'h5554, 16'hAAAA, 16'h5555};
        vecs[1] = '{18'h3FFFF, 18'h00000, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
        vecs[2] = '{18'h12345, 18'h0FFFF, 16'h2345, 16'hFFFF, 16'h48D1, 16'h3FFF};
        vecs[3] = '{18'h20001, 18'h1C003, 16'h0001, 16'hC003, 16'h8000, 16'h7000};

        i_rst = 1'b1; i_bck = 1'b0; i_dl = 1'b0; i_dr = 1'b0;
        i_ll = 1'b0;  i_lr = 1'b0;  i_hold = 1'b0;
        ticks(3);
        chk("rst_l", l16, 16'h0);
        chk("rst_r", r16, 16'h0);
        chk("rst_flags", {upd16, act16, ovr16}, 3'b000);
        chk("rst_l18", l18, 16'h0);
        i_rst = 1'b0;
        ticks(3);

        // Basic word with latency measurement.
        shift_word(18'h08001, 18'h07FFE, 16);
        @(negedge clk);
        i_ll = 1'b1;
        i_lr = 1'b1;
        base = upd_cnt;
        ticks(3);
        chk("lat_early", l16, 16'h0);
        ticks(1);
        chk("lat_l", l16, 16'h8001);
        chk("lat_r", r16, 16'h7FFE);
        chk("lat_act", act16, 1'b1);
        ticks(4);
        i_ll = 1'b0;
        i_lr = 1'b0;
        ticks(4);
        chk("lat_upd1", upd_cnt - base, 1);

        // Collision: bck and ll rise together.
        shift_word(18'h01357, 18'h0, 16);
        i_dl = 1'b1;
        i_bck = 1'b0;
        ticks(4);
        i_bck = 1'b1;
        i_ll = 1'b1;
        ticks(4);
        i_bck = 1'b0;
        i_ll = 1'b0;
        ticks(4);
        chk("coll_w1", l16, 16'h1357);
        shift_word(18'h02468, 18'h0, 15);
        pulse(1'b1, 1'b0);
        chk("coll_w2", l16, 16'hA468);

        // Table of 18-bit words seen by both widths.
        foreach (vecs[k]) begin
            shift_word(vecs[k].wl, vecs[k].wr, 18);
            pulse(1'b1, 1'b1);
            chk($sformatf("tbl%0d_l16", k), l16, vecs[k].el16);
            chk($sformatf("tbl%0d_r16", k), r16, vecs[k].er16);
            chk($sformatf("tbl%0d_l18", k), l18, vecs[k].el18);
            chk($sformatf("tbl%0d_r18", k), r18, vecs[k].er18);
        end

        // Hold defers commit.
        i_hold = 1'b1;
        ticks(4);
        shift_word(18'h2AAAB, 18'h0, 18);
        pulse(1'b1, 1'b0);
        changed = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (l16 !== 16'h0001 || l18 !== 16'h8000) changed = 1'b1;
        end
        chk("hold_nochg", changed, 1'b0);
        i_hold = 1'b0;
        ticks(2);
        chk("hold_2clk", l18, 16'h8000);
        ticks(1);
        chk("hold_3clk18", l18, 16'hAAAA);
        chk("hold_3clk16", l16, 16'hAAAB);
        chk("hold_no_ovr", ovr16, 1'b0);

        // Overrun under hold.
        i_hold = 1'b1;
        ticks(4);
        shift_word(18'h01234, 18'h0, 16);
        pulse(1'b1, 1'b0);
        shift_word(18'h05678, 18'h0, 16);
        pulse(1'b1, 1'b0);
        chk("ovr_set", ovr16, 1'b1);
        chk("ovr_held", l16, 16'hAAAB);
        i_hold = 1'b0;
        ticks(6);
        chk("ovr_data", l16, 16'h5678);

        // Watchdog mute.
        shift_word(18'h04000, 18'h04000, 16);
        pulse(1'b1, 1'b1);
        ticks(4);
        chk("wd_pre_l", l16, 16'h4000);
        chk("wd_pre_r", r16, 16'h4000);
        base = upd_cnt;
        n = 0;
        while (act16 && n < TMO + 200) begin
            @(negedge clk);
            n++;
        end
        chk("wd_fired", act16, 1'b0);
        chk("wd_time", (n >= TMO - 40) && (n <= TMO), 1'b1);
        ticks(10);
        chk("wd_l", l16, 16'h0);
        chk("wd_r", r16, 16'h0);
        chk("wd_upd1", upd_cnt - base, 1);
        chk("wd_act18", act18, 1'b0);
        chk("wd_ovr_sticky", ovr16, 1'b1);
        shift_word(18'h01111, 18'h02222, 16);
        pulse(1'b1, 1'b1);
        chk("wd_rest_act", act16, 1'b1);
        chk("wd_rest_l", l16, 16'h1111);

        // Reset mid-word.
        shift_word(18'h000A5, 18'h0005A, 8);
        @(negedge clk);
        #5;
        i_rst = 1'b1;
        #1;
        chk("mrst_l", l16, 16'h0);
        chk("mrst_r", r16, 16'h0);
        chk("mrst_flags", {act16, ovr16}, 2'b00);
        ticks(2);
        i_bck = 1'b0;
        i_rst = 1'b0;
        ticks(2);
        shift_word(18'h0BEEF, 18'h01234, 16);
        pulse(1'b1, 1'b1);
        chk("post_l", l16, 16'hBEEF);
        chk("post_r", r16, 16'h1234);
        chk("post_l18", l18, 16'h2FBB);
        chk("post_r18", r18, 16'h048D);
        chk("post_flags", {act16, ovr16}, 2'b10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
